// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: transfer direction, response status and the
// memory responder FSM states used by the RTL and bench monitors.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_RESPONDER_IDLE    = 2'b00,
        RGGEN_RESPONDER_WAIT    = 2'b01,
        RGGEN_RESPONDER_RESPOND = 2'b10
    } rggen_responder_state;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen bus: one outstanding request, completed by a single-cycle done
// carrying read data and status.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    rggen_direction           direction;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   write_strobe;
    logic                     done;
    logic [BUS_WIDTH-1:0]     read_data;
    rggen_status              status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );

    modport monitor (
        input request, address, direction, write_data, write_strobe,
        input done, read_data, status
    );
endinterface

// File: rtl/rggen_wait_counter.sv
// Loadable down-counter that stops at zero; zero flags the last wait cycle.
module rggen_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && !zero) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rggen_bus_memory_responder.sv
// rggen bus responder backed by a word-addressed register-file memory.
// RGGEN_BUS_RESPONDER_WAIT_EN enables WAIT_CYCLES of extra response latency.
module rggen_bus_memory_responder
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int WORDS         = 16,
    parameter int WAIT_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    rggen_bus_if.slave  bus_if,
    output logic        o_busy
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IW     = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef RGGEN_BUS_RESPONDER_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int EFF_WAIT = WAIT_EN ? WAIT_CYCLES : 0;

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        ADDRESS_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDRESS_WIDTH:0] WORD_LIMIT =
        (ADDRESS_WIDTH + 1)'(WORDS);

    rggen_responder_state state;
    rggen_responder_state state_next;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    rggen_direction           dir_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_W-1:0]        strb_q;

    logic [ADDRESS_WIDTH-1:0] acc_addr;
    rggen_direction           acc_dir;
    logic [DATA_WIDTH-1:0]    acc_wdata;
    logic [STRB_W-1:0]        acc_strb;
    logic [ADDRESS_WIDTH-1:0] acc_index;
    logic                     acc_error;
    logic [IW-1:0]            mem_index;

    logic accept;
    logic execute;
    logic cnt_zero;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic                  done_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    rggen_status           status_q;

    assign accept  = (state == RGGEN_RESPONDER_IDLE) && bus_if.request;
    assign execute = (state_next == RGGEN_RESPONDER_RESPOND);

    // With no wait, the access executes on its own capture edge.
    always_comb begin
        acc_addr  = addr_q;
        acc_dir   = dir_q;
        acc_wdata = wdata_q;
        acc_strb  = strb_q;
        if (state == RGGEN_RESPONDER_IDLE) begin
            acc_addr  = bus_if.address;
            acc_dir   = bus_if.direction;
            acc_wdata = bus_if.write_data;
            acc_strb  = bus_if.write_strobe;
        end
        acc_index = acc_addr >> LSB;
        acc_error = (|(acc_addr & ALIGN_MASK)) ||
                    ({1'b0, acc_index} >= WORD_LIMIT);
        mem_index = acc_index[IW-1:0];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RGGEN_RESPONDER_IDLE: begin
                if (bus_if.request) begin
                    state_next = (EFF_WAIT > 0) ? RGGEN_RESPONDER_WAIT
                                                : RGGEN_RESPONDER_RESPOND;
                end
            end
            RGGEN_RESPONDER_WAIT: begin
                if (cnt_zero) begin
                    state_next = RGGEN_RESPONDER_RESPOND;
                end
            end
            RGGEN_RESPONDER_RESPOND: begin
                state_next = RGGEN_RESPONDER_IDLE;
            end
            default: begin
                state_next = RGGEN_RESPONDER_IDLE;
            end
        endcase
    end

`ifdef RGGEN_BUS_RESPONDER_WAIT_EN
    localparam int CW = (EFF_WAIT > 1) ? $clog2(EFF_WAIT) : 1;
    localparam logic [CW-1:0] LOAD_VALUE =
        CW'((EFF_WAIT > 0) ? EFF_WAIT - 1 : 0);

    rggen_wait_counter #(
        .WIDTH (CW)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_value (LOAD_VALUE),
        .decrement  (state == RGGEN_RESPONDER_WAIT),
        .zero       (cnt_zero)
    );
`else
    assign cnt_zero = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RGGEN_RESPONDER_IDLE;
            addr_q  <= '0;
            dir_q   <= RGGEN_READ;
            wdata_q <= '0;
            strb_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= execute;
            busy_q <= (state_next != RGGEN_RESPONDER_IDLE);
            if (accept) begin
                addr_q  <= bus_if.address;
                dir_q   <= bus_if.direction;
                wdata_q <= bus_if.write_data;
                strb_q  <= bus_if.write_strobe;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
            rdata_q  <= '0;
            status_q <= RGGEN_OKAY;
        end else if (execute) begin
            rdata_q  <= '0;
            status_q <= RGGEN_OKAY;
            if (acc_error) begin
                status_q <= RGGEN_SLAVE_ERROR;
            end else if (acc_dir == RGGEN_READ) begin
                rdata_q <= mem[mem_index];
            end else begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (acc_strb[b]) begin
                        mem[mem_index][8*b+:8] <= acc_wdata[8*b+:8];
                    end
                end
            end
        end
    end

    assign bus_if.done      = done_q;
    assign bus_if.read_data = rdata_q;
    assign bus_if.status    = status_q;
    assign o_busy           = busy_q;
endmodule

// File: doc/rggen_bus_memory_responder.md
# rggen_bus_memory_responder

Responder end of the rggen bus protocol. It implements `rggen_bus_if.slave` on top of a small word-addressed register-file memory, so it can sit behind an external-register master as a real peripheral or as the standard bench model. It accepts one request at a time and returns exactly one single-cycle `done` with read data and status. It also applies optional wait states and flags accesses that are out of range or misaligned.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 8: width of `bus_if.address`, as a byte address.
- `DATA_WIDTH`, 32: bus data width; must be 8·2^n.
- `WORDS`, 16: memory depth in words; 1 ≤ WORDS ≤ 2^(ADDRESS_WIDTH−log2(DATA_WIDTH/8)).
- `WAIT_CYCLES`, 0: extra response latency in cycles; honoured only when the configuration macro is defined.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `bus_if` modport `rggen_bus_if.slave`: carries request, address, direction, write_data, write_strobe in, and done, read_data, status out.
- `o_busy` output 1: high from request acceptance through the `done` cycle inclusive.

## Operation
- FSM states:
  - IDLE: `request`=1 → capture address, direction, write_data, write_strobe; go to WAIT if effective wait > 0, else RESPOND.
  - WAIT: counter loaded with effective wait − 1; decrements each cycle; at 0 → RESPOND.
  - RESPOND: `done`=1 for this cycle only; → IDLE unconditionally. `request` is ignored in this cycle.
- Decode:
  - LSB = log2(DATA_WIDTH/8).
  - Word index = address[ADDRESS_WIDTH−1:LSB].
  - Error if address[LSB−1:0] ≠ 0, or if index ≥ WORDS.
- Execution happens on the clock edge that enters RESPOND, using the captured values:
  - Read OK: `read_data` ← mem[index]; `status` ← RGGEN_OKAY.
  - Write OK: mem[index] byte b ← write_data byte b for each set strobe bit; `read_data` ← 0; `status` ← RGGEN_OKAY.
  - Write with all strobe bits clear: no memory change; status OKAY.
  - Error: no memory change; `read_data` ← 0; `status` ← RGGEN_SLAVE_ERROR.
- `read_data` and `status` are held until the next execution. Masters sample them only in the `done` cycle.
- Protocol violations:
  - If `request` drops during WAIT, the access still completes and `done` still fires.
  - Input changes after capture are ignored.

## Timing
- Reset values:
  - `done` 0, `read_data` 0, `status` RGGEN_OKAY, `o_busy` 0.
  - FSM IDLE, wait counter 0, all memory words 0.
- Latency: `request` first high in cycle N → `done` high in cycle N+1+W, where W = effective wait.
- Back-to-back accesses: the master drops `request` in cycle N+2+W and may re-raise it in N+3+W. A read issued right after a write returns the written data.
- Reset asserted mid-access: the access is aborted, no `done` is produced, and all state and memory return to reset values immediately (asynchronously).
- All outputs are registered; there is no combinational path from bus inputs to `done`, `read_data` or `status`.

## Configuration
- Macro: `RGGEN_BUS_RESPONDER_WAIT_EN`.
- Defined: effective wait = `WAIT_CYCLES`; the WAIT state and counter are present.
- Undefined: counter and WAIT state are compiled out; `WAIT_CYCLES` is ignored; effective wait = 0, so `done` is always in cycle N+1.

## Structure
- Reuse `rggen_direction` and `rggen_status` from `rggen_rtl_pkg`.
- Add `rggen_responder_state` (IDLE/WAIT/RESPOND) to `rggen_rtl_pkg` so bench monitors can share it.
- One sub-module, `rggen_wait_counter`: loadable down-counter with a `zero` flag, instantiated only under the macro.
- The memory array stays inline.

## Test plan
All scenarios use DATA_WIDTH=32, WORDS=16, macro defined, WAIT_CYCLES=2.
- Reset, then read address 0x00 → `done` in cycle N+3, read_data 0x0000_0000, status OKAY.
- Write 0x3C data 0xDEAD_BEEF strobe 0xF, then read 0x3C → 0xDEAD_BEEF, OKAY, `o_busy` high exactly 3 cycles per access.
- Write 0x04 data 0x1122_3344 strobe 0xF, then write 0x04 data 0xAABB_CCDD strobe 0x5, then read 0x04 → 0x11BB_33DD.
- Read 0x40 (index 16) and write 0x06 (misaligned) → RGGEN_SLAVE_ERROR, read_data 0, memory unchanged on re-read.
- Pulse `rst_n` low in cycle N+1 of a write to 0x08 → no `done`, read of 0x08 returns 0.
- Recompile without the macro → every access produces `done` in cycle N+1, with data results identical to the scenarios above.
